// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file dump engine.
// NREGS must be even and no larger than 2**ADDR_W.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;
  localparam int PAIR_W = ADDR_W - 1;
  localparam int NPAIRS = NREGS / 2;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    CSUM,
    FIN
  } dump_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dump_beat_t;

  function automatic logic is_last_reg(input logic [ADDR_W-1:0] addr);
    return addr == ADDR_W'(NREGS - 1);
  endfunction

  function automatic logic is_last_pair(input logic [PAIR_W-1:0] pair);
    return pair == PAIR_W'(NPAIRS - 1);
  endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready beat stream carrying (address, data) pairs out of the dump engine.
interface regfile_dump_if;
  import regfile_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_buf.sv
// Two-entry beat buffer: loads a whole register pair at once, pops one beat at a time.
// A pair may load into an empty buffer or into one whose single entry pops this cycle.
module regfile_dump_buf
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       pop,
  input  dump_beat_t beat_a,
  input  dump_beat_t beat_b,
  output logic       valid,
  output logic       can_load,
  output dump_beat_t head
);

  logic [1:0] count_q, count_d;
  dump_beat_t ent0_q, ent0_d;
  dump_beat_t ent1_q, ent1_d;
  logic       pop_ok;

  assign pop_ok   = pop && (count_q != 2'd0);
  assign valid    = (count_q != 2'd0);
  assign can_load = (count_q == 2'd0) || ((count_q == 2'd1) && pop_ok);
  assign head     = ent0_q;

  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (load && can_load) begin
      ent0_d  = beat_a;
      ent1_d  = beat_b;
      count_d = 2'd2;
    end else if (pop_ok) begin
      ent0_d  = ent1_q;
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Sweeps the two-port register file a pair at a time and streams (addr, data) beats.
// Define REGFILE_DUMP_CHECKSUM_EN to append a running-sum beat after the last register.
module regfile_dump
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] readAddr1,
  output logic [ADDR_W-1:0] readAddr2,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  regfile_dump_if.master    out
);

  dump_state_t       state_q, state_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic              buf_valid;
  logic              buf_can_load;
  logic              load;
  logic              pop;
  logic              last_pop;
  logic              start_acc;
  dump_beat_t        head;
  dump_beat_t        beat_a;
  dump_beat_t        beat_b;

  // Read addresses come straight off the pair register, so they are stable all cycle.
  assign readAddr1 = {pair_q, 1'b0};
  assign readAddr2 = {pair_q, 1'b1};

  assign beat_a   = '{addr: readAddr1, data: readData1};
  assign beat_b   = '{addr: readAddr2, data: readData2};
  assign pop      = buf_valid && out.out_ready;
  assign last_pop = pop && is_last_reg(head.addr);

  regfile_dump_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .pop      (pop),
    .beat_a   (beat_a),
    .beat_b   (beat_b),
    .valid    (buf_valid),
    .can_load (buf_can_load),
    .head     (head)
  );

  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          pair_d    = '0;
          start_acc = 1'b1;
        end
      end
      READ: begin
        busy = 1'b1;
        if (buf_can_load) begin
          load   = 1'b1;
          pair_d = pair_q + PAIR_W'(1);
          if (is_last_pair(pair_q)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        if (last_pop) state_d = CSUM;
`else
        if (last_pop) state_d = FIN;
`endif
      end
      CSUM: begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
        busy = 1'b1;
        if (out.out_ready) state_d = FIN;
`else
        state_d = IDLE;
`endif
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_acc)
      sum_d = '0;
    else if (pop)
      sum_d = sum_q + head.data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  // The checksum beat is synthesised from state; the buffer is empty by then.
  always_comb begin
    out.out_valid = buf_valid;
    out.out_addr  = head.addr;
    out.out_data  = head.data;
    out.out_last  = 1'b0;
    if (state_q == CSUM) begin
      out.out_valid = 1'b1;
      out.out_addr  = '0;
      out.out_data  = sum_q;
      out.out_last  = 1'b1;
    end
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;

  always_comb begin
    out.out_valid = buf_valid;
    out.out_addr  = head.addr;
    out.out_data  = head.data;
    out.out_last  = buf_valid && is_last_reg(head.addr);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
    end
  end

endmodule
